trig_deadtime_gate: RTL
=======================

Name: trig_deadtime_gate

Overview:
Conditions a raw trigger line into clean single-cycle pulses for the downstream A/B alternating splitter.
- Synchronizes the raw input, detects rising edges and enforces a programmable dead time between accepted pulses.
- Counts accepted and vetoed edges for slow-control readout.
- Sits directly upstream of the ping-pong splitter; pulse_out drives its single-bit input.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on trig_in (min 2)
DEADTIME_W, 16, width of deadtime input and internal down-counter
CNT_W, 32, width of n_accepted / n_vetoed counters

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset (0 = reset)
trig_in  input  1  raw, asynchronous trigger level
enable  input  1  1 = edges may be accepted; 0 = edges ignored
deadtime  input  DEADTIME_W  dead time in clk cycles, sampled only at accept
cnt_clear  input  1  synchronous clear of both counters
pulse_out  output  1  one-cycle accepted-trigger pulse, registered
busy  output  1  registered; high while dead-time counter nonzero
n_accepted  output  CNT_W  saturating count of accepted edges
n_vetoed  output  CNT_W  saturating count of edges rejected during dead time

Behaviour:
- Reset (reset==0 at a clk edge), applied every cycle it is held:
  - pulse_out=0, busy=0, n_accepted=0, n_vetoed=0.
  - Dead-time counter=0, FSM=IDLE, all synchronizer and edge-delay flops=0.
- Synchronizer and edge detection:
  - trig_in passes through SYNC_STAGES flops; a delay flop holds the previous last-stage value.
  - edge = last_stage & ~delay.
- Latency: if trig_in is first sampled high at edge E0 and the edge is accepted, pulse_out is high for exactly one cycle following edge E0+SYNC_STAGES.
- FSM states:
  - IDLE (counter==0).
  - HOLD (counter!=0).
- IDLE transitions:
  - edge & enable: pulse_out<=1, n_accepted++, counter<=deadtime.
  - Go to HOLD if deadtime!=0, else stay in IDLE.
- HOLD transitions:
  - counter decrements by 1 each cycle; go to IDLE when it reaches 0.
  - edge & enable: no pulse, n_vetoed++.
- Minimum spacing between accepted pulses is deadtime+1 cycles.
  - With deadtime=0, edges 2 cycles apart are all accepted (edge-detect limit).
- busy is the registered value of (counter!=0) after the edge.
- Edges while enable==0 are neither accepted nor counted. Lowering enable in HOLD does not stop the countdown.
- deadtime changes have no effect on a running countdown.
- Counters:
  - Saturate at all-ones and never wrap.
  - cnt_clear wins over a simultaneous increment: both counters read 0 afterwards, and that cycle's event is lost.
  - cnt_clear does not affect the FSM or pulse_out.
- Reset mid-HOLD aborts the countdown. If trig_in is already high at reset release, it is seen as a fresh edge and accepted (if enabled) SYNC_STAGES cycles later.

Optional Feature:
TRIG_DEADTIME_GATE_VETO_EN
- Defined:
  - Adds port veto_in (input, 1, synchronous to clk, active high).
  - An edge arriving in IDLE while veto_in==1 is rejected: no pulse, no counter load, n_vetoed++.
  - veto_in has no effect in HOLD.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package/include trig_defs:
  - FSM state encodings ST_IDLE=1'b0, ST_HOLD=1'b1.
  - Default width constants for DEADTIME_W and CNT_W.
  - Saturating-increment helper function.
- One natural sub-module: sync_edge_det (SYNC_STAGES synchronizer plus rising-edge detector, active-low sync reset).
  - Reusable for other front-panel inputs.

Test Plan:
1. SYNC_STAGES=2, deadtime=4, enable=1, trig_in high from edge 10 for 10 cycles -> pulse_out high only in the cycle after edge 12; busy high 4 cycles; n_accepted=1, n_vetoed=0.
2. deadtime=4, trig_in 2 high / 2 low repeated for 6 rising edges -> pulses accepted and vetoed alternately; n_accepted=3, n_vetoed=3.
3. deadtime=0, trig_in toggling every cycle for 8 rising edges -> 8 pulses, 2 cycles apart; busy never high; n_vetoed=0.
4. deadtime=100, one accepted edge, reset low for 1 cycle 10 cycles later -> busy=0, counters=0, FSM IDLE; next edge accepted at nominal latency.
5. CNT_W=4, 20 accepted edges -> n_accepted holds at 15. cnt_clear coincident with the 21st accept -> n_accepted=0, pulse_out still asserted.
6. enable=0 with 5 edges -> no pulse_out, counters unchanged. With VETO_EN defined and veto_in=1 in IDLE -> no pulse, n_vetoed+1.

Source files
------------

// File: rtl/trig_deadtime_gate_pkg.sv
// Shared definitions for trig_deadtime_gate: FSM encoding, default widths and
// a saturating-increment helper.
package trig_deadtime_gate_pkg;

  localparam int DEADTIME_W_DEF = 16;
  localparam int CNT_W_DEF      = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Increments v unless it already equals the all-ones value of a w-bit field
  // (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/trig_deadtime_gate_if.sv
// Signal bundle between the trigger source/slow control and trig_deadtime_gate.
// veto_in exists only when TRIG_DEADTIME_GATE_VETO_EN is defined.
interface trig_deadtime_gate_if
  import trig_deadtime_gate_pkg::*;
#(
  parameter int DEADTIME_W = DEADTIME_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
);
  logic                  trig_in;
  logic                  enable;
  logic [DEADTIME_W-1:0] deadtime;
  logic                  cnt_clear;
`ifdef TRIG_DEADTIME_GATE_VETO_EN
  logic                  veto_in;
`endif
  logic                  pulse_out;
  logic                  busy;
  logic [CNT_W-1:0]      n_accepted;
  logic [CNT_W-1:0]      n_vetoed;

  modport master (
`ifdef TRIG_DEADTIME_GATE_VETO_EN
    output veto_in,
`endif
    output trig_in, enable, deadtime, cnt_clear,
    input  pulse_out, busy, n_accepted, n_vetoed
  );

  modport slave (
`ifdef TRIG_DEADTIME_GATE_VETO_EN
    input  veto_in,
`endif
    input  trig_in, enable, deadtime, cnt_clear,
    output pulse_out, busy, n_accepted, n_vetoed
  );
endinterface

// File: rtl/trig_deadtime_gate_sync_edge_det.sv
// Multi-flop synchronizer followed by a rising-edge detector; reusable for any
// asynchronous front-panel level. Synchronous active-low reset.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delay_q;

  // NOTE: reset is sampled only at the clock edge, so it sits inside the
  // edge-triggered block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's
      // pre-edge value, which is what turns this into a shift chain.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], level};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~delay_q;
endmodule

// File: rtl/trig_deadtime_gate.sv
// Trigger conditioner: synchronised edge -> single-cycle pulse with programmable
// dead time and saturating accept/veto counters. Option: TRIG_DEADTIME_GATE_VETO_EN.
module trig_deadtime_gate
  import trig_deadtime_gate_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEADTIME_W  = DEADTIME_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 reset,
  trig_deadtime_gate_if.slave bus
);
  state_t                state, state_nxt;
  logic [DEADTIME_W-1:0] count, count_nxt;
  logic                  rise;
  logic                  veto;
  logic                  accept, reject;
  logic                  pulse_q;
  logic [CNT_W-1:0]      n_acc_q, n_veto_q;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .level (bus.trig_in),
    .rise  (rise)
  );

`ifdef TRIG_DEADTIME_GATE_VETO_EN
  assign veto = bus.veto_in;
`else
  assign veto = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latch).
    count_nxt = count;
    unique case (state)
      ST_IDLE: if (accept) count_nxt = bus.deadtime;
      ST_HOLD: count_nxt = count - 1'b1;
    endcase
    state_nxt = (count_nxt != '0) ? ST_HOLD : ST_IDLE;
  end

  always_comb begin
    accept = 1'b0;
    reject = 1'b0;
    if (rise && bus.enable) begin
      unique case (state)
        ST_IDLE: begin
          accept = ~veto;
          reject = veto;
        end
        ST_HOLD: reject = 1'b1;
      endcase
    end
  end

  // A clear wins over a same-cycle increment; that event is simply not counted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pulse_q  <= 1'b0;
      n_acc_q  <= '0;
      n_veto_q <= '0;
    end else begin
      pulse_q <= accept;
      if (bus.cnt_clear) begin
        n_acc_q  <= '0;
        n_veto_q <= '0;
      end else begin
        if (accept) n_acc_q  <= CNT_W'(sat_inc(64'(n_acc_q), CNT_W));
        if (reject) n_veto_q <= CNT_W'(sat_inc(64'(n_veto_q), CNT_W));
      end
    end
  end

  assign bus.pulse_out  = pulse_q;
  assign bus.busy       = (state == ST_HOLD);
  assign bus.n_accepted = n_acc_q;
  assign bus.n_vetoed   = n_veto_q;
endmodule
